// File: rtl/mul_sgn_pkg.sv
// Shared definitions for the signed multiplier and its accumulate stage:
// speed encodings, accumulator width derivation and the clamping adder.
package mul_sgn_pkg;

  typedef enum logic [1:0] {
    SPEED_AREA     = 2'd0,
    SPEED_BALANCED = 2'd1,
    SPEED_FAST     = 2'd2
  } speed_e;

  localparam int SAT_ADD_W = 64;

  function automatic int width_a(input int wx, input int wy, input int guard);
    return wx + wy + guard;
  endfunction

  // Returns {sat, sum}: a+b clamped to the signed range of 'width' bits,
  // sign-extended to 64 bits.
  function automatic logic [SAT_ADD_W:0] sat_add(input logic signed [SAT_ADD_W-1:0] a,
                                                 input logic signed [SAT_ADD_W-1:0] b,
                                                 input int width);
    logic signed [SAT_ADD_W:0] s;
    logic signed [SAT_ADD_W:0] hi;
    logic signed [SAT_ADD_W:0] lo;
    s  = $signed({a[SAT_ADD_W-1], a}) + $signed({b[SAT_ADD_W-1], b});
    hi = (65'sd1 <<< (width - 1)) - 65'sd1;
    lo = -(65'sd1 <<< (width - 1));
    if (s > hi) begin
      return {1'b1, hi[SAT_ADD_W-1:0]};
    end else if (s < lo) begin
      return {1'b1, lo[SAT_ADD_W-1:0]};
    end else begin
      return {1'b0, s[SAT_ADD_W-1:0]};
    end
  endfunction

endpackage

// File: rtl/mul_sgn_acc_if.sv
// Product stream in, frame result out; shared between the multiplier side
// and the accumulate stage.
interface mul_sgn_acc_if #(
  parameter int widthX    = 8,
  parameter int widthY    = 8,
  parameter int guardBits = 8,
  parameter int maxTerms  = 256
);
  import mul_sgn_pkg::*;

  localparam int widthA = width_a(widthX, widthY, guardBits);
  localparam int widthC = $clog2(maxTerms + 1);

  logic                            in_valid;
  logic                            in_ready;
  logic signed [widthX+widthY-1:0] P;
  logic                            in_last;
  logic                            out_valid;
  logic                            out_ready;
  logic signed [widthA-1:0]        acc;
  logic [widthC-1:0]               cnt;
  logic                            ovf;

  modport master (
    output in_valid, P, in_last, out_ready,
    input  in_ready, out_valid, acc, cnt, ovf
  );

  modport slave (
    input  in_valid, P, in_last, out_ready,
    output in_ready, out_valid, acc, cnt, ovf
  );

  modport MulSgn_out (
    output P, in_valid, in_last,
    input  in_ready
  );

endinterface

// File: rtl/mul_sgn_acc_sat_adder.sv
// Combinational signed add of two W-bit values with clamp to the W-bit range
// and a saturate flag.
module sat_adder
  import mul_sgn_pkg::*;
#(
  parameter int W = 24
) (
  input  logic signed [W-1:0] a,
  input  logic signed [W-1:0] b,
  output logic signed [W-1:0] y,
  output logic                sat
);

  logic signed [SAT_ADD_W-1:0] a_ext_s;
  logic signed [SAT_ADD_W-1:0] b_ext_s;
  logic [SAT_ADD_W:0]          r_s;
  logic                        upper_bad_s;

  // Widen, add with clamp, and flag any result whose upper bits are not a clean sign extension.
  always_comb begin
    a_ext_s     = SAT_ADD_W'(a);
    b_ext_s     = SAT_ADD_W'(b);
    r_s         = sat_add(a_ext_s, b_ext_s, W);
    upper_bad_s = (r_s[SAT_ADD_W-1:W] != {(SAT_ADD_W-W){r_s[W-1]}});
    y           = r_s[W-1:0];
    sat         = r_s[SAT_ADD_W] | upper_bad_s;
  end

endmodule

// File: rtl/mul_sgn_acc.sv
// Saturating signed accumulate stage: sums a framed product stream and
// presents one registered result (sum, term count, overflow) per frame.
module mul_sgn_acc
  import mul_sgn_pkg::*;
#(
  parameter int widthX    = 8,
  parameter int widthY    = 8,
  parameter int guardBits = 8,
  parameter int maxTerms  = 256
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  mul_sgn_acc_if.slave  bus
);

  localparam int widthA = width_a(widthX, widthY, guardBits);
  localparam int widthC = $clog2(maxTerms + 1);
  localparam logic [widthC-1:0] CNT_MAX = widthC'(maxTerms);
  localparam logic [widthC-1:0] CNT_ONE = widthC'(1);

  logic signed [widthA-1:0] sum_q, sum_d;
  logic signed [widthA-1:0] acc_q, acc_d;
  logic [widthC-1:0]        tcnt_q, tcnt_d;
  logic [widthC-1:0]        cnt_q, cnt_d;
  logic                     sat_q, sat_d;
  logic                     ovf_q, ovf_d;
  logic                     out_valid_q, out_valid_d;

  logic signed [widthA-1:0] p_ext_s;
  logic signed [widthA-1:0] nsum_s;
  logic                     nsat_s;
  logic [widthC-1:0]        ntcnt_s;
  logic                     in_ready_s;
  logic                     in_acc_s;
  logic                     out_acc_s;

  assign in_ready_s = !out_valid_q || bus.out_ready;
  assign in_acc_s   = bus.in_valid && in_ready_s;
  assign out_acc_s  = out_valid_q && bus.out_ready;
  assign p_ext_s    = widthA'($signed(bus.P));
  assign ntcnt_s    = (tcnt_q >= CNT_MAX) ? CNT_MAX : (tcnt_q + CNT_ONE);

  sat_adder #(
    .W (widthA)
  ) u_sat_adder (
    .a   (sum_q),
    .b   (p_ext_s),
    .y   (nsum_s),
    .sat (nsat_s)
  );

  // Next-state: clr wins over an accepted product; in_last publishes and restarts the frame.
  always_comb begin
    sum_d  = sum_q;
    tcnt_d = tcnt_q;
    sat_d  = sat_q;
    acc_d  = acc_q;
    cnt_d  = cnt_q;
    ovf_d  = ovf_q;
    if (out_acc_s) begin
      out_valid_d = 1'b0;
    end else begin
      out_valid_d = out_valid_q;
    end
    if (clr) begin
      sum_d  = {widthA{1'b0}};
      tcnt_d = {widthC{1'b0}};
      sat_d  = 1'b0;
    end else if (in_acc_s && bus.in_last) begin
      acc_d       = nsum_s;
      cnt_d       = ntcnt_s;
      ovf_d       = sat_q | nsat_s;
      out_valid_d = 1'b1;
      sum_d       = {widthA{1'b0}};
      tcnt_d      = {widthC{1'b0}};
      sat_d       = 1'b0;
    end else if (in_acc_s) begin
      sum_d  = nsum_s;
      tcnt_d = ntcnt_s;
      sat_d  = sat_q | nsat_s;
    end else begin
      sum_d  = sum_q;
      tcnt_d = tcnt_q;
      sat_d  = sat_q;
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sum_q       <= {widthA{1'b0}};
      tcnt_q      <= {widthC{1'b0}};
      sat_q       <= 1'b0;
      acc_q       <= {widthA{1'b0}};
      cnt_q       <= {widthC{1'b0}};
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      sum_q       <= sum_d;
      tcnt_q      <= tcnt_d;
      sat_q       <= sat_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      ovf_q       <= ovf_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign bus.in_ready  = in_ready_s;
  assign bus.out_valid = out_valid_q;
  assign bus.acc       = acc_q;
  assign bus.cnt       = cnt_q;
  assign bus.ovf       = ovf_q;

endmodule

// File: tb/tb_mul_sgn_acc.sv
// Randomized and directed bench for mul_sgn_acc against a frame-level
// arithmetic model of the saturating accumulator.
module tb_mul_sgn_acc;

  localparam int     WA   = 24;
  localparam longint AMAX = (64'sd1 <<< (WA - 1)) - 64'sd1;
  localparam longint AMIN = -(64'sd1 <<< (WA - 1));
  localparam int     MAXT = 256;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic clr   = 1'b0;

  always #5 clk = ~clk;

  mul_sgn_acc_if b ();
  mul_sgn_acc_if #(.guardBits(0)) b0 ();

  mul_sgn_acc dut (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr),
    .bus   (b.slave)
  );

  mul_sgn_acc #(.guardBits(0)) dut0 (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr),
    .bus   (b0.slave)
  );

  int n_checks = 0;
  int n_fail   = 0;

  longint m_sum, m_acc;
  int     m_tcnt, m_cnt;
  bit     m_sat, m_ovf, m_ov;

  task automatic chk(input string tag, input longint obs, input longint exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    m_sum = 0; m_acc = 0; m_tcnt = 0; m_cnt = 0;
    m_sat = 1'b0; m_ovf = 1'b0; m_ov = 1'b0;
  endtask

  task automatic drv(input bit v, input int p, input bit l, input bit ordy);
    b.in_valid  = v;
    b.P         = 16'(p);
    b.in_last   = l;
    b.out_ready = ordy;
  endtask

  // One clock: check DUT against model at negedge, advance model, return #1 after posedge.
  task automatic step();
    longint pv, s;
    bit     ready, st;
    int     c;
    @(negedge clk);
    ready = !m_ov || b.out_ready;
    chk("in_ready", b.in_ready, ready);
    chk("out_valid", b.out_valid, m_ov);
    chk("acc", b.acc, m_acc);
    chk("cnt", b.cnt, m_cnt);
    chk("ovf", b.ovf, m_ovf);
    if (!rst_n) begin
      model_clear();
    end else begin
      if (m_ov && b.out_ready) m_ov = 1'b0;
      if (clr) begin
        m_sum = 0; m_tcnt = 0; m_sat = 1'b0;
      end else if (b.in_valid && ready) begin
        pv = b.P;
        s  = m_sum + pv;
        st = 1'b0;
        if (s > AMAX) begin
          s = AMAX; st = 1'b1;
        end else if (s < AMIN) begin
          s = AMIN; st = 1'b1;
        end
        c = (m_tcnt + 1 > MAXT) ? MAXT : m_tcnt + 1;
        if (b.in_last) begin
          m_acc = s; m_cnt = c; m_ovf = m_sat | st; m_ov = 1'b1;
          m_sum = 0; m_tcnt = 0; m_sat = 1'b0;
        end else begin
          m_sum = s; m_tcnt = c; m_sat = m_sat | st;
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    int p;
    drv(1'b0, 0, 1'b0, 1'b1);
    b0.in_valid = 1'b0; b0.P = 16'sd0; b0.in_last = 1'b0; b0.out_ready = 1'b1;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", b.in_ready, 1);
    chk("rst_out_valid", b.out_valid, 0);
    chk("rst_acc", b.acc, 0);
    chk("rst_cnt", b.cnt, 0);
    chk("rst_ovf", b.ovf, 0);
    rst_n = 1'b1;
    model_clear();

    // Basic frame 3, -5, 7
    drv(1'b1, 3, 1'b0, 1'b1);  step();
    drv(1'b1, -5, 1'b0, 1'b1); step();
    drv(1'b1, 7, 1'b1, 1'b1);  step();
    drv(1'b0, 0, 1'b0, 1'b1);
    chk("t1_acc", b.acc, 5);
    chk("t1_cnt", b.cnt, 3);
    chk("t1_ovf", b.ovf, 0);
    chk("t1_ov", b.out_valid, 1);
    step();
    chk("t1_ov_drop", b.out_valid, 0);

    // Saturation on a 16-bit accumulator, then a clean frame
    b0.in_valid = 1'b1; b0.P = 16'sd16384; b0.in_last = 1'b0;
    step(); step();
    b0.in_last = 1'b1;
    step();
    b0.in_valid = 1'b0; b0.in_last = 1'b0;
    chk("t2_acc", b0.acc, 32767);
    chk("t2_ovf", b0.ovf, 1);
    chk("t2_cnt", b0.cnt, 3);
    b0.in_valid = 1'b1; b0.P = 16'sd1; b0.in_last = 1'b1;
    step();
    b0.in_valid = 1'b0; b0.in_last = 1'b0;
    chk("t2b_acc", b0.acc, 1);
    chk("t2b_ovf", b0.ovf, 0);
    chk("t2b_cnt", b0.cnt, 1);

    // Back-to-back single-term frames
    for (int i = 1; i <= 3; i++) begin
      drv(1'b1, i, 1'b1, 1'b1);
      step();
      chk("t3_acc", b.acc, i);
      chk("t3_ready", b.in_ready, 1);
    end

    // Output stall then release with a pending in_last
    drv(1'b1, 11, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("t4_ready", b.in_ready, 0);
      chk("t4_acc", b.acc, 3);
    end
    b.out_ready = 1'b1;
    step();
    chk("t4_new_acc", b.acc, 11);
    chk("t4_ov", b.out_valid, 1);
    drv(1'b0, 0, 1'b0, 1'b1);
    step();

    // clr with an accepted product mid-frame
    drv(1'b1, 2, 1'b0, 1'b1); step();
    drv(1'b1, 9, 1'b0, 1'b1); clr = 1'b1; step();
    clr = 1'b0;
    drv(1'b1, 4, 1'b1, 1'b1); step();
    drv(1'b0, 0, 1'b0, 1'b1);
    chk("t5_acc", b.acc, 4);
    chk("t5_cnt", b.cnt, 1);

    // Reset mid-frame
    drv(1'b1, 5, 1'b0, 1'b1); step();
    drv(1'b1, 6, 1'b0, 1'b1); step();
    drv(1'b0, 0, 1'b0, 1'b1);
    rst_n = 1'b0; step(); rst_n = 1'b1;
    chk("t6_acc", b.acc, 0);
    chk("t6_cnt", b.cnt, 0);
    chk("t6_ov", b.out_valid, 0);
    drv(1'b1, 7, 1'b1, 1'b1); step();
    drv(1'b0, 0, 1'b0, 1'b1);
    chk("t6b_acc", b.acc, 7);
    chk("t6b_cnt", b.cnt, 1);

    // Long negative frame: count and sum both saturate
    for (int i = 0; i < 299; i++) begin
      drv(1'b1, -32768, 1'b0, 1'b1); step();
    end
    drv(1'b1, -32768, 1'b1, 1'b1); step();
    drv(1'b0, 0, 1'b0, 1'b1);
    chk("t7_acc", b.acc, AMIN);
    chk("t7_cnt", b.cnt, MAXT);
    chk("t7_ovf", b.ovf, 1);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      case ($urandom_range(0, 3))
        0:       p = -32768;
        1:       p = 32767;
        default: p = int'($urandom_range(0, 65535)) - 32768;
      endcase
      drv($urandom_range(0, 3) != 0, p, $urandom_range(0, 3) == 0, $urandom_range(0, 3) != 0);
      clr   = ($urandom_range(0, 31) == 0);
      rst_n = ($urandom_range(0, 199) != 0);
      step();
    end
    clr   = 1'b0;
    rst_n = 1'b1;
    drv(1'b0, 0, 1'b0, 1'b1);
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
